// File: rtl/rlc_iter.sv
// Iterative linear CORDIC, rotation mode: drives z toward zero while accumulating
// y += x*z / 2^CORDIC_QUAN, one micro-rotation per clock, single operation in flight.
module rlc_iter #(
  parameter int DATA_WIDTH  = 32,
  parameter int CORDIC_QUAN = 16,
  parameter int ITERS       = 16,
  parameter int K_START     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic [DATA_WIDTH-1:0] y_in,
  input  logic [DATA_WIDTH-1:0] z_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] x_out,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic [DATA_WIDTH-1:0] z_out,
  output logic                  busy
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int KW = $clog2(K_START + ITERS + 1) + 1;
  localparam logic signed [DATA_WIDTH-1:0] UNIT = DATA_WIDTH'(1) << CORDIC_QUAN;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                        r_state;
  logic [CW-1:0]                 r_cnt;
  logic signed [DATA_WIDTH-1:0]  r_x, r_y, r_z;
  logic                          r_in_ready, r_out_valid, r_busy;

  logic [KW-1:0]                 w_k;
  logic signed [DATA_WIDTH-1:0]  w_xs, w_us;
  logic                          w_neg;

  // Shift amount grows with the counter; both terms truncate toward -inf.
  assign w_k   = KW'(K_START) + KW'(r_cnt);
  assign w_xs  = r_x >>> w_k;
  assign w_us  = UNIT >>> w_k;
  assign w_neg = r_z[DATA_WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x        <= x_in;
            r_y        <= y_in;
            r_z        <= z_in;
            r_cnt      <= '0;
            r_state    <= RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          // Zero residual counts as positive, so d = +1 when the sign bit is clear.
          if (w_neg) begin
            r_y <= r_y - w_xs;
            r_z <= r_z + w_us;
          end else begin
            r_y <= r_y + w_xs;
            r_z <= r_z - w_us;
          end
          if (r_cnt == CW'(ITERS - 1)) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign x_out     = r_x;
  assign y_out     = r_y;
  assign z_out     = r_z;

endmodule
